mmse_gs_solver: RTL and testbench
=================================

# mmse_gs_solver

Iterative linear-system solver for the MMSE detector. It sits directly downstream of the pre-calculation stage. It accepts the 4x4 matrix A = H^H·H + snr·I and the vector b = H^H·r, and runs a fixed number of Gauss-Seidel sweeps to produce the symbol estimate x ≈ A⁻¹·b in Q(32-FRAC).FRAC fixed point. It computes one multiply-accumulate per cycle and uses a serial divider per row, trading latency for area.

## Interface
- N_ITER, 4, number of Gauss-Seidel sweeps (≥1)
- FRAC, 16, fractional bits of x_hat
- clk  input  1  single clock, all logic rising-edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  matrix_A/vector_b valid
- in_ready  output  1  block idle, can accept
- matrix_A  input  signed 32 [0:3][0:3]  system matrix, integer
- vector_b  input  signed 32 [0:3]  right-hand side, integer
- out_valid  output  1  x_hat valid, held until taken
- out_ready  input  1  consumer accepts x_hat
- x_hat  output  signed 32 [0:3]  solution, Q.FRAC
- div_err  output  1  a zero diagonal was hit during this solve

## Operation
- Reset values: in_ready=1, out_valid=0, div_err=0, x_hat all 0, state IDLE.
- States:
  - IDLE → MAC on in_valid&&in_ready. A and b are latched, x is cleared to 0, iter=0, row i=0, j=0, and div_err is cleared.
  - MAC: 4 cycles, j=0..3. The accumulator (signed 64) is initialised to b_i<<<FRAC. Each cycle subtracts A[i][j]·x[j]. The j==i term is masked to 0. The x values used are the most recent, so row updates within a sweep are visible (Gauss-Seidel, not Jacobi).
  - DSTART: 1 cycle. Loads the divider with dividend = acc (64 b) and divisor = A[i][i].
  - DIV: 64 cycles, serial signed divide. The quotient truncates toward zero.
  - WB: 1 cycle. The quotient is saturated to [-2^31, 2^31-1] and written to x[i].
    - If A[i][i]==0, the divider is bypassed in effect: x[i]=0 is written and div_err is set sticky for this solve (the state timing stays unchanged).
    - Then i++. When i wraps 3→0, iter++. If iter reaches N_ITER, go to OUT, otherwise go to MAC.
  - OUT: out_valid=1, and x_hat/div_err are driven from the internal registers and held stable. On out_ready, go to IDLE next cycle with out_valid=0.
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored (no queueing).
- x_hat is updated only on entry to OUT. It holds its previous result during a solve.
- Accumulator width: the product is 64 b. The sum of b<<FRAC and three products may overflow 64 b. That case is out of range for the system (|A|,|b| < 2^24 guaranteed by the upstream scaling), and the RTL wraps silently.
- Reset mid-solve: any state returns to IDLE on the next edge, all outputs go to their reset values, and the partial result is discarded.

## Timing
- Per row: 4 MAC + 1 DSTART + 64 DIV + 1 WB = 70 cycles. Per sweep: 280 cycles.
- Acceptance at edge T0 (in_valid&&in_ready sampled high). out_valid is first high in cycle T0 + 280·N_ITER + 1, i.e. 1121 cycles for N_ITER=4.
- Handshake on output: the transfer occurs on the edge with out_valid&&out_ready. in_ready rises the cycle after that transfer.
- Accept and output transfer never coincide, because IDLE and OUT are distinct states. The minimum initiation interval is 280·N_ITER + 2 cycles.

## Structure
- Shared package mimo_pkg:
  - DATA_W=32, ACC_W=64.
  - typedef enum for solver states (IDLE, MAC, DSTART, DIV, WB, OUT).
  - typedefs mat4_t and vec4_t of signed [31:0].
- Sub-module serial_sdiv:
  - 64/32 signed restoring divider.
  - Interface: start, dividend, divisor, busy, done, quotient.
  - Fixed 64-cycle latency, result valid on done.
  - Quotient truncates toward zero. Divide-by-zero returns 0 and raises dz.

## Test plan
- Identity: A=I, b={1,2,3,4}, N_ITER=4 → x_hat={65536,131072,196608,262144}, div_err=0, out_valid at T0+1121.
- Diagonal: A=diag(2,4,8,16), b={1,1,1,1} → x_hat={32768,16384,8192,4096}. Negative b={-3,0,0,0} with A=diag(2,...) → x_hat[0]=-98304.
- Tridiagonal: rows {4,1,0,0},{1,4,1,0},{0,1,4,1},{0,0,1,4}, b={5,6,6,5}, N_ITER=8 → each x_hat within 65536±64.
- Zero diagonal: A[2][2]=0, other diagonal 1, off-diagonal 0, b={1,1,1,1} → x_hat[2]=0, div_err=1, others 65536.
- Backpressure: out_ready low for 50 cycles after out_valid → x_hat stable, in_ready=0, and a new in_valid is ignored. After out_ready, in_ready=1 one cycle later.
- Reset at cycle T0+300 → next cycle in_ready=1, out_valid=0, x_hat=0. A fresh identity solve then completes at its own T0+1121.

Source files
------------

// File: rtl/mimo_pkg.sv
// Shared types for the MMSE detector: widths, solver states, matrix/vector types.
// sext() widens a data word to accumulator width.
package mimo_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DSTART,
    DIV,
    WB,
    OUT
  } state_t;

  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef word_t vec4_t [0:3];
  typedef vec4_t mat4_t [0:3];

  function automatic acc_t sext(input word_t w);
    return {{(ACC_W-DATA_W){w[DATA_W-1]}}, w};
  endfunction

endpackage

// File: rtl/mmse_gs_solver_if.sv
// Handshake bundle of the Gauss-Seidel solver.
// Input side: in_valid/in_ready + A,b. Output side: out_valid/out_ready + x_hat, div_err.
interface mmse_gs_solver_if;
  import mimo_pkg::*;

  logic  in_valid;
  logic  in_ready;
  mat4_t matrix_A;
  vec4_t vector_b;
  logic  out_valid;
  logic  out_ready;
  vec4_t x_hat;
  logic  div_err;

  modport master (
    output in_valid, matrix_A, vector_b, out_ready,
    input  in_ready, out_valid, x_hat, div_err
  );

  modport slave (
    input  in_valid, matrix_A, vector_b, out_ready,
    output in_ready, out_valid, x_hat, div_err
  );

endinterface

// File: rtl/serial_sdiv.sv
// 64/32 signed restoring divider, one quotient bit per cycle, 64-cycle latency.
// Ports: start/dividend/divisor in; busy, done (1-cycle pulse), dz, quotient out.
module serial_sdiv
  import mimo_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  input  acc_t  dividend,
  input  word_t divisor,
  output logic  busy,
  output logic  done,
  output logic  dz,
  output acc_t  quotient
);

  logic [ACC_W-1:0]  mag;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvs;
  logic [5:0]        cnt;
  logic              neg;
  logic [DATA_W:0]   trial;
  logic              ge;

  // Remainder stays below dvs, so the shifted trial fits DATA_W+1 bits
  // and the restored difference fits DATA_W bits.
  assign trial = {rem, mag[ACC_W-1]};
  assign ge    = trial >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      mag  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      neg  <= 1'b0;
      dz   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      mag  <= dividend[ACC_W-1] ? -dividend : dividend;
      dvs  <= divisor[DATA_W-1] ? -divisor : divisor;
      rem  <= '0;
      cnt  <= '0;
      neg  <= dividend[ACC_W-1] ^ divisor[DATA_W-1];
      dz   <= divisor == '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      rem  <= ge ? trial[DATA_W-1:0] - dvs : trial[DATA_W-1:0];
      mag  <= {mag[ACC_W-2:0], ge};
      cnt  <= cnt + 6'd1;
      busy <= cnt != 6'd63;
      done <= cnt == 6'd63;
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = dz  ? '0 :
                    neg ? -$signed(mag) : $signed(mag);

endmodule

// File: rtl/mmse_gs_solver.sv
// Gauss-Seidel solver for the 4x4 MMSE system A*x = b; x_hat in Q.FRAC.
// Ports: clk, reset (sync, high), bus (slave side of mmse_gs_solver_if).
module mmse_gs_solver
  import mimo_pkg::*;
#(
  parameter int N_ITER = 4,
  parameter int FRAC   = 16
) (
  input logic             clk,
  input logic             reset,
  mmse_gs_solver_if.slave bus
);

  state_t      state;
  mat4_t       a;
  vec4_t       b;
  vec4_t       x;
  vec4_t       xh;
  acc_t        acc;
  logic [1:0]  i;
  logic [1:0]  j;
  logic [5:0]  dcnt;
  logic [15:0] iter;
  logic        err;
  logic        in_rdy;
  logic        out_vld;

  acc_t        prod;
  acc_t        acc_nxt;
  acc_t        div_q;
  logic        div_busy;
  logic        div_done;
  logic        div_dz;
  logic        div_unused;
  word_t       q_sat;
  word_t       wb_val;
  vec4_t       x_new;

  localparam acc_t QMAX = 64'sd2147483647;
  localparam acc_t QMIN = -64'sd2147483648;

  // Diagonal term is masked; x holds the freshest values (Gauss-Seidel).
  assign prod    = (i == j) ? '0 : sext(a[i][j]) * sext(x[j]);
  assign acc_nxt = ((j == 2'd0) ? (sext(b[i]) <<< FRAC) : acc) - prod;

  serial_sdiv u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (state == DSTART),
    .dividend (acc),
    .divisor  (a[i][i]),
    .busy     (div_busy),
    .done     (div_done),
    .dz       (div_dz),
    .quotient (div_q)
  );

  // Sequencing is cycle-counted, so busy/done are not needed here.
  assign div_unused = div_busy ^ div_done;

  always_comb begin
    if (div_q > QMAX) begin
      q_sat = 32'sh7fffffff;
    end else if (div_q < QMIN) begin
      q_sat = 32'sh80000000;
    end else begin
      q_sat = div_q[DATA_W-1:0];
    end
  end

  assign wb_val = div_dz ? '0 : q_sat;

  always_comb begin
    x_new    = x;
    x_new[i] = wb_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '{default: '0};
      b       <= '{default: '0};
      x       <= '{default: '0};
      xh      <= '{default: '0};
      acc     <= '0;
      i       <= '0;
      j       <= '0;
      dcnt    <= '0;
      iter    <= '0;
      err     <= 1'b0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a      <= bus.matrix_A;
            b      <= bus.vector_b;
            x      <= '{default: '0};
            iter   <= '0;
            i      <= '0;
            j      <= '0;
            err    <= 1'b0;
            in_rdy <= 1'b0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          j   <= j + 2'd1;
          if (j == 2'd3) begin
            state <= DSTART;
          end
        end
        DSTART: begin
          dcnt  <= '0;
          state <= DIV;
        end
        DIV: begin
          dcnt <= dcnt + 6'd1;
          if (dcnt == 6'd63) begin
            state <= WB;
          end
        end
        WB: begin
          x <= x_new;
          i <= i + 2'd1;
          if (div_dz) begin
            err <= 1'b1;
          end
          if (i != 2'd3) begin
            state <= MAC;
          end else if (iter == 16'(N_ITER - 1)) begin
            xh      <= x_new;
            out_vld <= 1'b1;
            state   <= OUT;
          end else begin
            iter  <= iter + 16'd1;
            state <= MAC;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.x_hat     = xh;
  assign bus.div_err   = err;

endmodule

// File: tb/tb_mmse_gs_solver.sv
// Self-checking bench for mmse_gs_solver: directed cases, random systems
// against a longint Gauss-Seidel model, handshake and reset behaviour.
module tb_mmse_gs_solver;
  import mimo_pkg::*;

  localparam int NI   = 4;
  localparam int NI8  = 8;
  localparam int FRC  = 16;
  localparam int LAT  = 280 * NI;
  localparam int LAT8 = 280 * NI8;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mmse_gs_solver_if bus ();
  mmse_gs_solver_if bus8 ();

  mmse_gs_solver #(.N_ITER(NI), .FRAC(FRC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mmse_gs_solver #(.N_ITER(NI8), .FRAC(FRC)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  function automatic void model(input mat4_t a, input vec4_t b,
                                input int n, output vec4_t x,
                                output logic e);
    longint xs[4];
    longint acc;
    longint q;
    for (int k = 0; k < 4; k++) xs[k] = 0;
    e = 1'b0;
    for (int it = 0; it < n; it++) begin
      for (int r = 0; r < 4; r++) begin
        acc = longint'(b[r]) * (longint'(1) << FRC);
        for (int c = 0; c < 4; c++)
          if (c != r) acc -= longint'(a[r][c]) * xs[c];
        if (a[r][r] == 0) begin
          xs[r] = 0;
          e = 1'b1;
        end else begin
          q = acc / longint'(a[r][r]);
          if (q > 64'sd2147483647) q = 64'sd2147483647;
          if (q < -64'sd2147483648) q = -64'sd2147483648;
          xs[r] = q;
        end
      end
    end
    for (int k = 0; k < 4; k++) x[k] = xs[k][31:0];
  endfunction

  function automatic mat4_t diag(input int d0, input int d1,
                                 input int d2, input int d3);
    mat4_t m;
    m = '{default: '0};
    m[0][0] = d0;
    m[1][1] = d1;
    m[2][2] = d2;
    m[3][3] = d3;
    return m;
  endfunction

  function automatic vec4_t vec(input int v0, input int v1,
                                input int v2, input int v3);
    vec4_t v;
    v[0] = v0;
    v[1] = v1;
    v[2] = v2;
    v[3] = v3;
    return v;
  endfunction

  function automatic logic outv(input bit s);
    return s ? bus8.out_valid : bus.out_valid;
  endfunction

  function automatic vec4_t xget(input bit s);
    return s ? bus8.x_hat : bus.x_hat;
  endfunction

  task automatic start_solve(input bit s, input mat4_t a, input vec4_t b);
    @(negedge clk);
    if (s) begin
      bus8.matrix_A = a;
      bus8.vector_b = b;
      bus8.in_valid = 1'b1;
    end else begin
      bus.matrix_A = a;
      bus.vector_b = b;
      bus.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus8.in_valid = 1'b0;
  endtask

  // lat = edges after the accept edge until out_valid is seen
  task automatic wait_out(input bit s, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (outv(s) !== 1'b1 && lat < 6000);
  endtask

  task automatic take_out(input bit s);
    @(negedge clk);
    if (s) bus8.out_ready = 1'b1;
    else bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready  = 1'b0;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vec4_t xg;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    xg = bus.x_hat;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.div_err !== 1'b0) begin
      errors++;
      $display("FAIL reset div_err: got %b expected 0", bus.div_err);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (xg[k] !== 0) begin
        errors++;
        $display("FAIL reset x_hat[%0d]: got %0d expected 0", k, xg[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed(input string nm, input mat4_t a,
                               input vec4_t b, input vec4_t xe,
                               input logic ee);
    int    lat;
    vec4_t xg;
    start_solve(0, a, b);
    wait_out(0, lat);
    xg = bus.x_hat;
    checks++;
    if (lat + 1 !== LAT + 1) begin
      errors++;
      $display("FAIL %s latency: got T0+%0d expected T0+%0d",
               nm, lat + 1, LAT + 1);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (xg[k] !== xe[k]) begin
        errors++;
        $display("FAIL %s x_hat[%0d]: got %0d expected %0d",
                 nm, k, xg[k], xe[k]);
      end
    end
    checks++;
    if (bus.div_err !== ee) begin
      errors++;
      $display("FAIL %s div_err: got %b expected %b", nm, bus.div_err, ee);
    end
    take_out(0);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got in_ready=%b out_valid=%b expected 1/0",
               nm, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_random();
    mat4_t a;
    vec4_t b;
    vec4_t xe;
    vec4_t xg;
    logic  ee;
    int    lat;
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 4; p++) begin
        for (int q = 0; q < 4; q++)
          a[p][q] = int'($urandom_range(128)) - 64;
        a[p][p] = int'($urandom_range(512)) - 256;
        b[p] = int'($urandom_range(2000)) - 1000;
      end
      if (r == 3) a[r % 4][r % 4] = 0;
      model(a, b, NI, xe, ee);
      start_solve(0, a, b);
      wait_out(0, lat);
      xg = bus.x_hat;
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL random%0d latency: got %0d expected %0d", r, lat, LAT);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (xg[k] !== xe[k]) begin
          errors++;
          $display("FAIL random%0d x_hat[%0d]: got %0d expected %0d",
                   r, k, xg[k], xe[k]);
        end
      end
      checks++;
      if (bus.div_err !== ee) begin
        errors++;
        $display("FAIL random%0d div_err: got %b expected %b",
                 r, bus.div_err, ee);
      end
      take_out(0);
    end
  endtask

  task automatic test_tridiag();
    mat4_t a;
    vec4_t b;
    vec4_t xe;
    vec4_t xg;
    logic  ee;
    int    lat;
    a = diag(4, 4, 4, 4);
    a[0][1] = 1; a[1][0] = 1; a[1][2] = 1;
    a[2][1] = 1; a[2][3] = 1; a[3][2] = 1;
    b = vec(5, 6, 6, 5);
    model(a, b, NI8, xe, ee);
    start_solve(1, a, b);
    wait_out(1, lat);
    xg = xget(1);
    checks++;
    if (lat !== LAT8) begin
      errors++;
      $display("FAIL tridiag latency: got %0d expected %0d", lat, LAT8);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (xg[k] > 65536 + 64 || xg[k] < 65536 - 64) begin
        errors++;
        $display("FAIL tridiag tol x_hat[%0d]: got %0d expected 65536+-64",
                 k, xg[k]);
      end
      checks++;
      if (xg[k] !== xe[k]) begin
        errors++;
        $display("FAIL tridiag x_hat[%0d]: got %0d expected %0d",
                 k, xg[k], xe[k]);
      end
    end
    take_out(1);
  endtask

  task automatic test_backpressure();
    vec4_t xe;
    vec4_t xg;
    int    lat;
    xe = vec(4 * 65536, 3 * 65536, 2 * 65536, 65536);
    start_solve(0, diag(1, 1, 1, 1), vec(4, 3, 2, 1));
    wait_out(0, lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL bp latency: got %0d expected %0d", lat, LAT);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.matrix_A = diag(7, 7, 7, 7);
      bus.vector_b = vec(9, 9, 9, 9);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      xg = bus.x_hat;
      checks++;
      if (xg != xe || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp hold c%0d: got x0=%0d rdy=%b vld=%b expected %0d/0/1",
                 c, xg[0], bus.in_ready, bus.out_valid, xe[0]);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp release: got in_ready=%b out_valid=%b expected 1/0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp ignored: got in_ready=%b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int    c0;
    int    c1;
    int    lat;
    vec4_t xg;
    c0 = -1;
    c1 = -1;
    bus.matrix_A  = diag(2, 2, 2, 2);
    bus.vector_b  = vec(2, 4, 6, -8);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        if (c0 < 0) c0 = c;
        else begin
          c1 = c;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (c1 - c0 !== LAT + 2) begin
      errors++;
      $display("FAIL b2b interval: got %0d expected %0d", c1 - c0, LAT + 2);
    end
    wait_out(0, lat);
    xg = bus.x_hat;
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL b2b latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (xg[3] !== -4 * 65536 || xg[1] !== 2 * 65536) begin
      errors++;
      $display("FAIL b2b x_hat: got %0d,%0d expected %0d,%0d",
               xg[1], xg[3], 2 * 65536, -4 * 65536);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b release: got in_ready=%b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    vec4_t prev;
    vec4_t xg;
    prev = bus.x_hat;
    start_solve(0, diag(1, 1, 1, 1), vec(5, 6, 7, 8));
    repeat (299) @(posedge clk);
    #1;
    xg = bus.x_hat;
    checks++;
    if (xg != prev) begin
      errors++;
      $display("FAIL mid hold x_hat[0]: got %0d expected %0d", xg[0], prev[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    xg = bus.x_hat;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid reset hs: got in_ready=%b out_valid=%b expected 1/0",
               bus.in_ready, bus.out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (xg[k] !== 0) begin
        errors++;
        $display("FAIL mid reset x_hat[%0d]: got %0d expected 0", k, xg[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    test_directed("mid_fresh", diag(1, 1, 1, 1), vec(1, 2, 3, 4),
                  vec(65536, 131072, 196608, 262144), 1'b0);
  endtask

  initial begin
    mat4_t m;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.matrix_A   = '{default: '0};
    bus.vector_b   = '{default: '0};
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.matrix_A  = '{default: '0};
    bus8.vector_b  = '{default: '0};
    test_reset();
    test_directed("identity", diag(1, 1, 1, 1), vec(1, 2, 3, 4),
                  vec(65536, 131072, 196608, 262144), 1'b0);
    test_directed("diagonal", diag(2, 4, 8, 16), vec(1, 1, 1, 1),
                  vec(32768, 16384, 8192, 4096), 1'b0);
    test_directed("negative", diag(2, 4, 8, 16), vec(-3, 0, 0, 0),
                  vec(-98304, 0, 0, 0), 1'b0);
    test_directed("saturate", diag(1, 1, 1, 1),
                  vec(1 << 20, -(1 << 20), 32767, -32768),
                  vec(32'sh7fffffff, 32'sh80000000, 2147418112,
                      32'sh80000000), 1'b0);
    m = diag(1, 1, 0, 1);
    test_directed("zero_diag", m, vec(1, 1, 1, 1),
                  vec(65536, 65536, 0, 65536), 1'b1);
    test_random();
    test_tridiag();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
